// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: frame-checker FSM states
// and the parity-type encoding used on par_typ.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_parity_calc.sv
// Expected parity bit for a received word: even parity yields the XOR of the data,
// odd parity yields its complement.
module uart_rx_parity_calc
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART frame checker: tracks start/data/parity/stop position from per-bit strobes and
// reports one registered result per frame. Define RX_ERR_CNT_EN to add error counters.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
`ifdef RX_ERR_CNT_EN
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  glitch_cnt,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stop_err_cnt,
`endif
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done,
  output logic                  data_valid,
  output logic                  start_glitch,
  output logic                  parity_err,
  output logic                  stop_err
);

  localparam int CW  = $clog2(DATA_WIDTH);
  localparam int SCW = 1;

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      CNT_WIDTH < 1) begin : g_bad_params
    $error("uart_rx_frame_check: illegal parameter value");
  end

  rx_state_t             state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0]        stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  fin_serr;
  logic                  glitch_ev;
  logic                  done_ev;
  logic                  exp_par;

  uart_rx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_calc (
    .data    (shift_q),
    .par_typ (par_typ_q),
    .par_bit (exp_par)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    perr_d     = perr_q;
    serr_d     = serr_q;
    fin_serr   = serr_q;
    glitch_ev  = 1'b0;
    done_ev    = 1'b0;
    unique case (state_q)
      // A bit_valid coinciding with frame_start belongs to the previous line state.
      IDLE: if (frame_start) state_d = START;
      START: if (bit_valid) begin
        if (sampled_bit) begin
          glitch_ev = 1'b1;
          state_d   = IDLE;
        end else begin
          par_en_d   = par_en;
          par_typ_d  = par_typ;
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
          shift_d    = '0;
          perr_d     = 1'b0;
          serr_d     = 1'b0;
          state_d    = DATA;
        end
      end
      DATA: if (bit_valid) begin
        shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
          bit_cnt_d = '0;
          state_d   = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: if (bit_valid) begin
        if (sampled_bit != exp_par) perr_d = 1'b1;
        state_d = STOP;
      end
      STOP: if (bit_valid) begin
        fin_serr = serr_q | ~sampled_bit;
        serr_d   = fin_serr;
        if (stop_cnt_q == SCW'(STOP_BITS - 1)) begin
          done_ev    = 1'b1;
          perr_d     = 1'b0;
          serr_d     = 1'b0;
          stop_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      perr_q       <= 1'b0;
      serr_q       <= 1'b0;
      data_out     <= '0;
      frame_done   <= 1'b0;
      data_valid   <= 1'b0;
      start_glitch <= 1'b0;
      parity_err   <= 1'b0;
      stop_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      perr_q       <= perr_d;
      serr_q       <= serr_d;
      frame_done   <= done_ev;
      data_valid   <= done_ev & ~(perr_q | fin_serr);
      start_glitch <= glitch_ev;
      parity_err   <= done_ev & perr_q;
      stop_err     <= done_ev & fin_serr;
      // Loaded even on error so software can inspect the corrupted word.
      if (done_ev) data_out <= shift_q;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef RX_ERR_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RST || cnt_clr) begin
      glitch_cnt   <= '0;
      par_err_cnt  <= '0;
      stop_err_cnt <= '0;
    end else begin
      if (glitch_ev && glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
      if (done_ev && perr_q && par_err_cnt != '1) par_err_cnt <= par_err_cnt + 1'b1;
      if (done_ev && fin_serr && stop_err_cnt != '1) stop_err_cnt <= stop_err_cnt + 1'b1;
    end
  end
`endif

endmodule
